// File: rtl/pio_pkg.sv
// Shared definitions for the PIO instruction encoder: opcodes, field widths, FSM states.
package pio_pkg;

    localparam logic [2:0] OP_JMP  = 3'd0;
    localparam logic [2:0] OP_WAIT = 3'd1;
    localparam logic [2:0] OP_IN   = 3'd2;
    localparam logic [2:0] OP_OUT  = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_IRQ  = 3'd6;
    localparam logic [2:0] OP_SET  = 3'd7;

    localparam int unsigned OpW     = 3;
    localparam int unsigned FieldW  = 5;
    localparam int unsigned Op1W    = 3;
    localparam int unsigned Op2W    = 5;
    localparam int unsigned WordW   = OpW + FieldW + Op1W + Op2W;

    localparam logic [2:0] SIDESET_MAX = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite,
        StDone
    } enc_state_e;

    function automatic logic [2:0] clamp_sideset(input logic [2:0] ss);
        return (ss > SIDESET_MAX) ? SIDESET_MAX : ss;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: builds {op, F, op1, op2} with the delay/side-set field truncated.
// The overflow output exists only when ENCODER_CHECK_EN is defined.
module instr_pack
    import pio_pkg::*;
(
    input  logic [OpW-1:0]    op_i,
    input  logic [Op1W-1:0]   op1_i,
    input  logic [Op2W-1:0]   op2_i,
    input  logic [FieldW-1:0] delay_i,
    input  logic [FieldW-1:0] side_set_i,
    input  logic [2:0]        sideset_bits_i,
`ifdef ENCODER_CHECK_EN
    output logic              overflow_o,
`endif
    output logic [WordW-1:0]  word_o
);

    logic [2:0]        ss;
    logic [FieldW-1:0] mask;
    logic [FieldW-1:0] field;

    always_comb begin
        ss    = clamp_sideset(sideset_bits_i);
        // 5-bit arithmetic: for ss=5 the shift yields 0 and the subtract wraps to all ones.
        mask  = (5'd1 << ss) - 5'd1;
        field = (delay_i << ss) | (side_set_i & mask);
        word_o = {op_i, field, op1_i, op2_i};
    end

`ifdef ENCODER_CHECK_EN
    always_comb begin
        overflow_o = ((delay_i >> (3'd5 - ss)) != 5'd0) ||
                     (side_set_i > mask) ||
                     (sideset_bits_i > SIDESET_MAX);
    end
`endif

endmodule

// File: rtl/instr_encoder.sv
// Program-load encoder: accepts instruction fields, packs them and writes one word per two cycles.
// Optional field-overflow checking is built when ENCODER_CHECK_EN is defined.
module instr_encoder
    import pio_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                 pclk,
    input  logic                 resetn,
    input  logic                 load_start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [ADDR_BITS:0]   length,
    input  logic [2:0]           sideset_bits,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [2:0]           op1,
    input  logic [4:0]           op2,
    input  logic [4:0]           delay,
    input  logic [4:0]           side_set,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [15:0]          mem_wdata,
    output logic                 done,
    output logic                 err_overflow,
    output logic [ADDR_BITS-1:0] err_addr
);

    localparam logic [ADDR_BITS-1:0] AddrOne = 1;
    localparam logic [ADDR_BITS:0]   RemOne  = 1;

    enc_state_e           state_q;
    logic                 in_ready_q;
    logic                 mem_we_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic [15:0]          mem_wdata_q;
    logic                 done_q;
    logic [ADDR_BITS:0]   remaining_q;
    logic [2:0]           sideset_q;
    logic [15:0]          packed_word;
    logic                 handshake;

`ifdef ENCODER_CHECK_EN
    logic                 overflow;
    logic                 err_overflow_q;
    logic [ADDR_BITS-1:0] err_addr_q;
`endif

    instr_pack u_pack (
        .op_i           (op),
        .op1_i          (op1),
        .op2_i          (op2),
        .delay_i        (delay),
        .side_set_i     (side_set),
        .sideset_bits_i (sideset_q),
`ifdef ENCODER_CHECK_EN
        .overflow_o     (overflow),
`endif
        .word_o         (packed_word)
    );

    assign handshake = in_valid && in_ready_q;

    // Outputs are registered alongside the state so each is high exactly in its own state.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= StIdle;
            in_ready_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            done_q         <= 1'b0;
            remaining_q    <= '0;
            sideset_q      <= '0;
`ifdef ENCODER_CHECK_EN
            err_overflow_q <= 1'b0;
            err_addr_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_start) begin
                        mem_addr_q     <= start_addr;
                        remaining_q    <= length;
                        sideset_q      <= sideset_bits;
`ifdef ENCODER_CHECK_EN
                        err_overflow_q <= 1'b0;
                        err_addr_q     <= '0;
`endif
                        if (length == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= StLoad;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (handshake) begin
                        mem_wdata_q <= packed_word;
                        mem_we_q    <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state_q     <= StWrite;
`ifdef ENCODER_CHECK_EN
                        if (overflow && !err_overflow_q) begin
                            err_overflow_q <= 1'b1;
                            err_addr_q     <= mem_addr_q;
                        end
`endif
                    end
                end
                StWrite: begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= mem_addr_q + AddrOne;
                    remaining_q <= remaining_q - RemOne;
                    if (remaining_q == RemOne) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= StLoad;
                        in_ready_q <= 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;

`ifdef ENCODER_CHECK_EN
    assign err_overflow = err_overflow_q;
    assign err_addr     = err_addr_q;
`else
    assign err_overflow = 1'b0;
    assign err_addr     = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; expectations follow ENCODER_CHECK_EN.
module tb_instr_encoder;
    import pio_pkg::*;

    localparam int unsigned AW = 5;
`ifdef ENCODER_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    logic          pclk;
    logic          resetn;
    logic          load_start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic [2:0]    sideset_bits;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [2:0]    op1;
    logic [4:0]    op2;
    logic [4:0]    delay;
    logic [4:0]    side_set;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          done;
    logic          err_overflow;
    logic [AW-1:0] err_addr;

    instr_encoder #(.ADDR_BITS(AW)) dut (
        .pclk         (pclk),
        .resetn       (resetn),
        .load_start   (load_start),
        .start_addr   (start_addr),
        .length       (length),
        .sideset_bits (sideset_bits),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .op1          (op1),
        .op2          (op2),
        .delay        (delay),
        .side_set     (side_set),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .done         (done),
        .err_overflow (err_overflow),
        .err_addr     (err_addr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] log_addr[$];
    logic [15:0]   log_data[$];

    always @(negedge pclk) begin
        if (resetn && mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    // Called at a falling edge; returns one falling edge later.
    task automatic load(input logic [AW-1:0] sa, input logic [AW:0] len, input logic [2:0] ss);
        start_addr   = sa;
        length       = len;
        sideset_bits = ss;
        load_start   = 1'b1;
        @(negedge pclk);
        load_start   = 1'b0;
    endtask

    // Returns at the falling edge inside the WRITE cycle.
    task automatic send(input logic [2:0] o, input logic [2:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [4:0] s);
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge pclk);
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        op       = o;
        op1      = a;
        op2      = b;
        delay    = d;
        side_set = s;
        in_valid = 1'b1;
        @(negedge pclk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before;
        logic [AW-1:0] ea;

        resetn = 1'b0; load_start = 1'b0; start_addr = '0; length = '0; sideset_bits = '0;
        in_valid = 1'b0; op = '0; op1 = '0; op2 = '0; delay = '0; side_set = '0;
        repeat (2) @(negedge pclk);
        chk("rst_we",      {31'd0, mem_we}, 32'd0);
        chk("rst_addr",    {27'd0, mem_addr}, 32'd0);
        chk("rst_wdata",   {16'd0, mem_wdata}, 32'd0);
        chk("rst_ready",   {31'd0, in_ready}, 32'd0);
        chk("rst_done",    {31'd0, done}, 32'd0);
        chk("rst_err",     {31'd0, err_overflow}, 32'd0);
        chk("rst_erraddr", {27'd0, err_addr}, 32'd0);
        resetn = 1'b1;
        @(negedge pclk);
        chk("idle_ready",  {31'd0, in_ready}, 32'd0);

        // Single word, no side-set.
        clear_log();
        load(5'd0, 6'd1, 3'd0);
        chk("t1_ready", {31'd0, in_ready}, 32'd1);
        send(OP_JMP, 3'd0, 5'd5, 5'd3, 5'd0);
        chk("t1_we",    {31'd0, mem_we}, 32'd1);
        chk("t1_addr",  {27'd0, mem_addr}, 32'd0);
        chk("t1_data",  {16'd0, mem_wdata}, 32'h0305);
        @(negedge pclk);
        chk("t1_done",  {31'd0, done}, 32'd1);
        chk("t1_we_lo", {31'd0, mem_we}, 32'd0);
        @(negedge pclk);
        chk("t1_done_lo", {31'd0, done}, 32'd0);
        chk("t1_nwr",   log_addr.size(), 32'd1);

        // Two side-set bits.
        load(5'd0, 6'd1, 3'd2);
        send(OP_JMP, 3'd0, 5'd5, 5'd3, 5'd2);
        chk("t2_data", {16'd0, mem_wdata}, 32'h0E05);
        chk("t2_err",  {31'd0, err_overflow}, 32'd0);
        wait_done("t2_done");
        @(negedge pclk);

        // Address wrap 30,31,0,1.
        clear_log();
        load(5'd30, 6'd4, 3'd0);
        for (int i = 0; i < 4; i++) send(3'(i), 3'd0, 5'(i + 1), 5'd0, 5'd0);
        wait_done("t3_done");
        chk("t3_nwr", log_addr.size(), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            ea = 5'(30 + i);
            chk($sformatf("t3_addr%0d", i), {27'd0, log_addr[i]}, {27'd0, ea});
            chk($sformatf("t3_data%0d", i), {16'd0, log_data[i]}, (i << 13) | (i + 1));
        end
        @(negedge pclk);

        // Zero-length load.
        clear_log();
        load(5'd3, 6'd0, 3'd0);
        chk("t4_done",  {31'd0, done}, 32'd1);
        chk("t4_ready", {31'd0, in_ready}, 32'd0);
        @(negedge pclk);
        chk("t4_done_lo", {31'd0, done}, 32'd0);
        chk("t4_nwr", log_addr.size(), 32'd0);

        // SET opcode, and load_start while in LOAD is ignored.
        clear_log();
        load(5'd5, 6'd2, 3'd0);
        send(OP_SET, 3'd0, 5'd1, 5'd0, 5'd0);
        chk("t5_data", {16'd0, mem_wdata}, 32'hE001);
        chk("t5_addr", {27'd0, mem_addr}, 32'd5);
        @(negedge pclk);
        load(5'd20, 6'd0, 3'd0);
        chk("t5_ign_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_ign_done",  {31'd0, done}, 32'd0);
        send(OP_JMP, 3'd0, 5'd2, 5'd0, 5'd0);
        chk("t5_addr2", {27'd0, mem_addr}, 32'd6);
        chk("t5_data2", {16'd0, mem_wdata}, 32'h0002);
        wait_done("t5_done");
        @(negedge pclk);

        // Overflow on the second word at address 9.
        load(5'd8, 6'd3, 3'd3);
        send(OP_JMP, 3'd0, 5'd0, 5'd1, 5'd2);
        chk("t6_data0", {16'd0, mem_wdata}, 32'h0A00);
        chk("t6_err0",  {31'd0, err_overflow}, 32'd0);
        send(OP_WAIT, 3'd2, 5'd3, 5'd4, 5'd0);
        chk("t6_data1", {16'd0, mem_wdata}, 32'h2043);
        chk("t6_addr1", {27'd0, mem_addr}, 32'd9);
        chk("t6_err1",  {31'd0, err_overflow}, {31'd0, CheckEn});
        chk("t6_eaddr1", {27'd0, err_addr}, CheckEn ? 32'd9 : 32'd0);
        send(OP_JMP, 3'd0, 5'd0, 5'd7, 5'd0);
        chk("t6_data2", {16'd0, mem_wdata}, 32'h1800);
        chk("t6_eaddr2", {27'd0, err_addr}, CheckEn ? 32'd9 : 32'd0);
        wait_done("t6_done");
        @(negedge pclk);
        load(5'd0, 6'd0, 3'd0);
        chk("t6_err_clr", {31'd0, err_overflow}, 32'd0);
        chk("t6_eaddr_clr", {27'd0, err_addr}, 32'd0);
        @(negedge pclk);

        // sideset_bits above 5 behaves as 5.
        load(5'd12, 6'd1, 3'd7);
        send(OP_IN, 3'd1, 5'd4, 5'd1, 5'd3);
        chk("t7_data", {16'd0, mem_wdata}, 32'h4324);
        chk("t7_err",  {31'd0, err_overflow}, {31'd0, CheckEn});
        chk("t7_eaddr", {27'd0, err_addr}, CheckEn ? 32'd12 : 32'd0);
        wait_done("t7_done");
        @(negedge pclk);

        // Reset during WRITE.
        clear_log();
        load(5'd0, 6'd3, 3'd0);
        send(OP_OUT, 3'd0, 5'd9, 5'd0, 5'd0);
        chk("t8_we", {31'd0, mem_we}, 32'd1);
        chk("t8_data", {16'd0, mem_wdata}, 32'h6009);
        #2;
        n_before = log_addr.size();
        resetn = 1'b0;
        #1;
        chk("t8_rst_we",    {31'd0, mem_we}, 32'd0);
        chk("t8_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("t8_rst_addr",  {27'd0, mem_addr}, 32'd0);
        chk("t8_rst_data",  {16'd0, mem_wdata}, 32'd0);
        @(negedge pclk);
        resetn = 1'b1;
        repeat (5) @(negedge pclk);
        chk("t8_no_writes", log_addr.size(), n_before);
        chk("t8_idle_ready", {31'd0, in_ready}, 32'd0);
        chk("t8_idle_done",  {31'd0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_BITS, default 5, SHALL set instruction-memory address width (32 slots).
REQ-002 pclk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 load_start  in  1  single-cycle pulse; begins a program load.
REQ-005 start_addr  in  ADDR_BITS  first write address, sampled on accepted load_start.
REQ-006 length  in  ADDR_BITS+1  instruction count (0..32), sampled on accepted load_start.
REQ-007 sideset_bits  in  3  side-set field width (0..5), sampled on accepted load_start.
REQ-008 in_valid  in  1  instruction fields valid.
REQ-009 in_ready  out  1  encoder accepts fields this cycle.
REQ-010 op  in  3  opcode; op1  in  3  field A; op2  in  5  field B; delay  in  5; side_set  in  5.
REQ-011 mem_we  out  1; mem_addr  out  ADDR_BITS; mem_wdata  out  16: instruction-memory write port.
REQ-012 done  out  1  one-cycle pulse at load end.
REQ-013 err_overflow  out  1  sticky field-overflow flag; err_addr  out  ADDR_BITS  address of first offending word.

Function
REQ-014 Word SHALL be {op, F, op1, op2}: F = ((delay << sideset_bits) | (side_set & mask)) truncated to 5 bits, mask = 2^sideset_bits - 1.
REQ-015 FSM states SHALL be IDLE, LOAD, WRITE, DONE.
REQ-016 IDLE: in_ready=0; load_start -> latch start_addr/length/sideset_bits, clear err flags; length=0 -> DONE, else -> LOAD.
REQ-017 load_start outside IDLE SHALL be ignored.
REQ-018 LOAD: in_ready=1; on in_valid&in_ready register encoded word, -> WRITE.
REQ-019 WRITE: mem_we=1 for exactly one cycle with registered addr/word; addr increments modulo 2^ADDR_BITS; remaining decrements; remaining==1 -> DONE else LOAD.
REQ-020 Latency: mem_we SHALL assert the cycle after the handshake; throughput one word per two cycles.
REQ-021 DONE: done=1 one cycle, -> IDLE.
REQ-022 mem_we, in_ready, done SHALL be 0 in all states other than those stated.
REQ-023 Address SHALL wrap 31->0 without error or stall.

Reset
REQ-024 On resetn low, immediately: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, done=0, err_overflow=0, err_addr=0, remaining=0.
REQ-025 Reset mid-load SHALL abort; no partial mem_we SHALL follow deassertion.

Configuration
REQ-026 Macro ENCODER_CHECK_EN defined: overflow = delay >= 2^(5-sideset_bits) or side_set > mask or sideset_bits > 5; first overflow sets err_overflow and err_addr; word still written truncated; sideset_bits > 5 encoded as 5.
REQ-027 ENCODER_CHECK_EN undefined: no check logic; err_overflow and err_addr tied 0; truncation per REQ-014 (sideset_bits > 5 clamped to 5).

Structure
REQ-028 Shared package pio_pkg SHALL hold opcode constants (JMP=0 ... SET=7), field widths, FSM state enum.
REQ-029 Sub-module instr_pack (combinational packer + overflow check) SHALL be used; everything else in instr_encoder.

Verification
REQ-030 sideset_bits=0, start_addr=0, length=1; op=0,op1=0,op2=5,delay=3 -> mem_we once, addr 0, data 0x0305, done next cycle.
REQ-031 sideset_bits=2; op=0,op2=5,delay=3,side_set=2 -> data 0x0E05, err_overflow=0.
REQ-032 start_addr=30, length=4 -> writes at 30,31,0,1 in order, then done.
REQ-033 ENCODER_CHECK_EN, sideset_bits=3, delay=4 at 2nd word, start_addr=8 -> err_overflow=1, err_addr=9, word written with F=(4<<3) truncated; next load_start clears flag.
REQ-034 length=0 -> no mem_we, done pulse 1 cycle after load_start; resetn low during WRITE -> mem_we=0 immediately, state IDLE, no writes after release.
REQ-035 op=7,op1=0,op2=1,delay=0, sideset_bits=0 -> data 0xE001; load_start during LOAD ignored.
